uart_rxsm: RTL and testbench
============================

Name: uart_rxsm

Overview:
Receive state machine and deserializer for the Parallel Interface UART. It is the counterpart of the transmit state machine.
- Oversamples RxD at 16x the baud rate.
- Qualifies start bits, then assembles 7- or 8-bit LSB-first words with optional parity.
- Checks parity and stop, detects break.
- Writes each data word plus status into the receive FIFO, which sits above this block.
- Format inputs come from the shared format decoder in the upper-level module.

Parameters:
pSyncLen, 2, number of RxD synchronizer flops (2..3).

Ports:
Clk  in  1  system clock
Rst  in  1  reset, asynchronous, active-low
CE_16x  in  1  16x baud-rate clock enable, one Clk wide
Len  in  1  0 = 8 data bits; 1 = 7 data bits (parity always received)
ParEn  in  1  parity bit present (8-bit words)
Par  in  2  0 = odd, 1 = even, 2 = space (0), 3 = mark (1)
RxD  in  1  asynchronous serial input, idle high
RF_FF  in  1  receive FIFO full flag
RF_WE  out  1  receive FIFO write strobe, one Clk
RF_WD  out  11  {BRK, FE, PE, Data[7:0]}; Data[7]=0 for 7-bit
OE  out  1  overrun: word dropped because RF_FF; sticky until next accepted write
RxIdle  out  1  state == pIdle
RxStart  out  1  state == pStartBit
RxShift  out  1  state in pShift0..pShift7 or pParity
RxStop  out  1  state == pStopBit or pBreak

Behaviour:
- Reset (Rst=0, asynchronous):
  - state = pIdle.
  - Bit = 0.
  - Synchronizer flops = 1.
  - RF_WE = 0, RF_WD = 0, OE = 0.
  - Shift register cleared.
- RxDs: RxD after pSyncLen flops. All sampling uses RxDs.
- Bit counter Bit[3:0]:
  - Held at 0 in pIdle.
  - Otherwise increments on each CE_16x and wraps 15 -> 0.
- Sample point: CE_16x with Bit == 7 (mid-bit). Call this SMP.
- pIdle:
  - On CE_16x with RxDs == 0, go to pStartBit. Bit is 0 on entry.
- pStartBit:
  - At SMP, if the sample is 1 (false start), go to pIdle with no write.
  - Else go to pShift0.
- pShift0..pShift6:
  - At SMP, shift the sample into Data[n] and advance.
  - After pShift6: Len=1 goes to pParity; Len=0 goes to pShift7.
- pShift7:
  - At SMP, capture Data[7].
  - Then ParEn=1 goes to pParity, else pStopBit.
- pParity:
  - At SMP, capture P.
  - PE = (Par==0 and P != ~^data) or (Par==1 and P != ^data) or (Par==2 and P==1) or (Par==3 and P==0).
  - data is the 7 or 8 received bits.
- pStopBit: at SMP, S = sample.
  - FE = ~S.
  - BRK = ~S and all data bits 0 and (parity bit 0 or no parity).
  - NumStop is ignored: only the first stop bit is checked, the second is treated as idle.
  - Write decision, same Clk:
    - If RF_FF=0: RF_WE=1 for one Clk, RF_WD loaded, OE cleared.
    - If RF_FF=1: no write, OE set.
  - Next state: BRK goes to pBreak; otherwise pIdle (the next start edge is found from mid-stop, giving half-bit resync).
- pBreak:
  - Stay until a CE_16x with RxDs == 1, then go to pIdle.
  - No further writes while the line stays low.
- Latency: RF_WE asserts on the Clk after the stop-bit SMP.
- RF_WD is held until the next write.
- Simultaneous events: an RF_FF change in the same Clk as the write decision uses the current value.
- CE_16x while RF_WE is high has no interaction.
- Unused or illegal state encodings recover to pIdle on the next Clk.

Optional Feature:
Macro UART_RXSM_MAJORITY_VOTE_EN.
- Defined:
  - Each bit is sampled at Bit == 6, 7 and 8.
  - The bit value is the 2-of-3 majority.
  - The decision and state transition happen at Bit == 8.
  - RF_WE moves one CE_16x later than in the undefined case.
  - Start qualification also uses the majority.
- Undefined: single sample at Bit == 7 as above.

Test Plan:
- 8N1, CE_16x every Clk, byte 0x55 -> one RF_WE, RF_WD = 0x055, RxIdle again after mid-stop.
- Len=1, Par=1 (even), byte 0x41 with P=0 -> RF_WD = 0x041. Same frame with P=1 -> RF_WD = 0x141 (PE set).
- 8N1, 0xA5 with stop bit 0 then line high -> RF_WD = 0x2A5 (FE only). All-zero frame held low for 3 character times -> exactly one write, RF_WD = 0x600, RxStop held until RxD high.
- RxD low glitch of 4 CE_16x periods -> no RF_WE, return to pIdle. In the majority build, a 1-tick glitch at Bit==7 inside data bit 3 of 0x00 -> RF_WD = 0x000.
- RF_FF=1 during a 0x3C frame -> no RF_WE, OE=1. Next frame with RF_FF=0 -> RF_WE, OE=0.
- Rst asserted mid-pShift4 -> all outputs to reset values immediately. After release, a new 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_rxsm_if.sv
// Bundle of format, serial-line and receive-FIFO signals around the UART receive
// state machine. The master drives the format, the line and the FIFO-full flag.
// The slave (uart_rxsm) drives the FIFO write port and the state flags.
interface uart_rxsm_if;
  logic        CE_16x;
  logic        Len;
  logic        ParEn;
  logic [1:0]  Par;
  logic        RxD;
  logic        RF_FF;
  logic        RF_WE;
  logic [10:0] RF_WD;
  logic        OE;
  logic        RxIdle;
  logic        RxStart;
  logic        RxShift;
  logic        RxStop;

  modport master (
    output CE_16x, Len, ParEn, Par, RxD, RF_FF,
    input  RF_WE, RF_WD, OE, RxIdle, RxStart, RxShift, RxStop
  );

  modport slave (
    input  CE_16x, Len, ParEn, Par, RxD, RF_FF,
    output RF_WE, RF_WD, OE, RxIdle, RxStart, RxShift, RxStop
  );
endinterface

// File: rtl/uart_rxsm.sv
// UART receive state machine and deserializer, 16x oversampled.
// It qualifies start bits and assembles 7/8-bit LSB-first words with optional parity.
// It checks parity and stop and detects break, then writes {BRK, FE, PE, Data} to the FIFO.
// Optional build macro UART_RXSM_MAJORITY_VOTE_EN: each bit becomes the 2-of-3 majority
// of the samples at Bit == 6, 7 and 8, and the decision is taken at Bit == 8.
module uart_rxsm #(
  parameter int unsigned pSyncLen = 2
) (
  input logic        Clk,
  input logic        Rst,
  uart_rxsm_if.slave bus
);

  typedef enum logic [3:0] {
    pIdle     = 4'd0,
    pStartBit = 4'd1,
    pShift0   = 4'd2,
    pShift1   = 4'd3,
    pShift2   = 4'd4,
    pShift3   = 4'd5,
    pShift4   = 4'd6,
    pShift5   = 4'd7,
    pShift6   = 4'd8,
    pShift7   = 4'd9,
    pParity   = 4'd10,
    pStopBit  = 4'd11,
    pBreak    = 4'd12
  } state_e;

  state_e              state_q, state_d;
  logic [pSyncLen-1:0] sync_q;
  logic                rxds;
  logic [3:0]          bit_q;
  logic [7:0]          data_q;
  logic                par_q;
  logic                pe_q;
  logic                rf_we_q;
  logic [10:0]         rf_wd_q;
  logic                oe_q;
  logic                smp;
  logic                sample;
  logic                brk;
  logic                pe_calc;
  logic [3:0]          shift_rel;

  assign rxds = sync_q[pSyncLen-1];

`ifdef UART_RXSM_MAJORITY_VOTE_EN
  logic s6_q, s7_q;

  // Hold the early and mid samples so the vote can be formed at Bit == 8
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      s6_q <= 1'b1;
      s7_q <= 1'b1;
    end else if (bus.CE_16x) begin
      if (bit_q == 4'd6) s6_q <= rxds;
      if (bit_q == 4'd7) s7_q <= rxds;
    end
  end

  assign smp    = bus.CE_16x && (bit_q == 4'd8);
  assign sample = (s6_q & s7_q) | (s6_q & rxds) | (s7_q & rxds);
`else
  assign smp    = bus.CE_16x && (bit_q == 4'd7);
  assign sample = rxds;
`endif

  // Break: low stop, all-zero data and a zero (or absent, hence cleared) parity bit
  assign brk       = ~sample & (data_q == 8'h00) & ~par_q;
  assign shift_rel = 4'(state_q) - 4'(pShift0);

  // Parity error from the bit being sampled now against the received data
  always_comb begin
    pe_calc = 1'b0;
    unique case (bus.Par)
      2'd0:    pe_calc = (sample != ~^data_q);
      2'd1:    pe_calc = (sample != ^data_q);
      2'd2:    pe_calc = sample;
      default: pe_calc = ~sample;
    endcase
  end

  // RxD synchronizer, idle-high out of reset
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) sync_q <= '1;
    else      sync_q <= {sync_q[pSyncLen-2:0], bus.RxD};
  end

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= pIdle;
    else      state_q <= state_d;
  end

  // Next-state logic; unused encodings fall back to pIdle
  always_comb begin
    state_d = state_q;
    case (state_q)
      pIdle:     if (bus.CE_16x && !rxds) state_d = pStartBit;
      pStartBit: if (smp) state_d = sample ? pIdle : pShift0;
      pShift0:   if (smp) state_d = pShift1;
      pShift1:   if (smp) state_d = pShift2;
      pShift2:   if (smp) state_d = pShift3;
      pShift3:   if (smp) state_d = pShift4;
      pShift4:   if (smp) state_d = pShift5;
      pShift5:   if (smp) state_d = pShift6;
      pShift6:   if (smp) state_d = bus.Len ? pParity : pShift7;
      pShift7:   if (smp) state_d = bus.ParEn ? pParity : pStopBit;
      pParity:   if (smp) state_d = pStopBit;
      // Leaving at mid-stop lets the next start edge resync half a bit early
      pStopBit:  if (smp) state_d = brk ? pBreak : pIdle;
      pBreak:    if (bus.CE_16x && rxds) state_d = pIdle;
      default:   state_d = pIdle;
    endcase
  end

  // State flags
  always_comb begin
    bus.RxIdle  = (state_q == pIdle);
    bus.RxStart = (state_q == pStartBit);
    bus.RxShift = (state_q inside {[pShift0:pShift7], pParity});
    bus.RxStop  = (state_q == pStopBit) || (state_q == pBreak);
    bus.RF_WE   = rf_we_q;
    bus.RF_WD   = rf_wd_q;
    bus.OE      = oe_q;
  end

  // Bit counter, deserializer, status capture and FIFO write decision
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      bit_q   <= 4'd0;
      data_q  <= 8'h00;
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
      rf_we_q <= 1'b0;
      rf_wd_q <= 11'h000;
      oe_q    <= 1'b0;
    end else begin
      rf_we_q <= 1'b0;
      if (state_q == pIdle) bit_q <= 4'd0;
      else if (bus.CE_16x)  bit_q <= bit_q + 4'd1;
      if (smp) begin
        case (state_q)
          // Clearing here keeps Data[7] zero for 7-bit words and PE/parity zero without parity
          pStartBit: begin
            data_q <= 8'h00;
            par_q  <= 1'b0;
            pe_q   <= 1'b0;
          end
          pShift0, pShift1, pShift2, pShift3,
          pShift4, pShift5, pShift6, pShift7: data_q[shift_rel[2:0]] <= sample;
          pParity: begin
            par_q <= sample;
            pe_q  <= pe_calc;
          end
          pStopBit: begin
            if (!bus.RF_FF) begin
              rf_we_q <= 1'b1;
              rf_wd_q <= {brk, ~sample, pe_q, data_q};
              oe_q    <= 1'b0;
            end else begin
              oe_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rxsm.sv
// Self-checking bench for uart_rxsm. Expected FIFO words are queued when a frame
// is driven and are checked against each RF_WE pulse.
module tb_uart_rxsm;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  uart_rxsm_if bus ();

  uart_rxsm #(.pSyncLen(2)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int          n_cmp  = 0;
  int          n_bad  = 0;
  int          wr_cnt = 0;
  int          ce_div = 1;
  int          ce_cnt = 0;
  logic [10:0] exp_q[$];

  always #5 Clk = ~Clk;

  // Clock enable: one Clk wide, once every ce_div cycles
  always @(negedge Clk) begin
    if (ce_cnt >= ce_div - 1) begin
      bus.CE_16x = 1'b1;
      ce_cnt = 0;
    end else begin
      bus.CE_16x = 1'b0;
      ce_cnt++;
    end
  end

  // Scoreboard: every write must match the oldest queued word
  always @(negedge Clk) begin
    logic [10:0] e;
    if (Rst && bus.RF_WE === 1'b1) begin
      wr_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: RF_WD=%h, required no write", bus.RF_WD);
      end else begin
        e = exp_q.pop_front();
        if (bus.RF_WD !== e) begin
          n_bad++;
          $display("FAIL rf_wd: got %h, required %h", bus.RF_WD, e);
        end
      end
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge Clk); while (bus.CE_16x !== 1'b1);
      #1;
    end
  endtask

  // Drive one frame (start, data LSB first, optional parity, one stop), 16 ticks per bit.
  // glitch inverts the line for that single tick; limit truncates the frame.
  task automatic send(input logic [7:0] d, input int ndata, input bit has_par,
                      input logic p, input logic stop, input int glitch, input int limit);
    logic [11:0] v;
    int          nb;
    v    = '1;
    v[0] = 1'b0;
    for (int i = 0; i < ndata; i++) v[1+i] = d[i];
    nb = 1 + ndata;
    if (has_par) begin
      v[nb] = p;
      nb++;
    end
    v[nb] = stop;
    nb++;
    for (int t = 0; t < nb * 16 && t < limit; t++) begin
      bus.RxD = (t == glitch) ? ~v[t/16] : v[t/16];
      ticks(1);
    end
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_missing_write: %0d words pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.RF_WE !== 1'b0 || bus.OE !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_we_oe: got %b%b, required 00", bus.RF_WE, bus.OE);
    end
    n_cmp++;
    if (bus.RF_WD !== 11'h000) begin
      n_bad++;
      $display("FAIL reset_wd: got %h, required 000", bus.RF_WD);
    end
    n_cmp++;
    if ({bus.RxIdle, bus.RxStart, bus.RxShift, bus.RxStop} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, required 1000",
               {bus.RxIdle, bus.RxStart, bus.RxShift, bus.RxStop});
    end
  endtask

  task automatic test_8n1();
    int w0;
    w0 = wr_cnt;
    bus.Len = 1'b0; bus.ParEn = 1'b0;
    exp_q.push_back(11'h055);
    send(8'h55, 8, 0, 1'b0, 1'b1, -1, 1000);
    n_cmp++;
    if (bus.RxIdle !== 1'b1) begin
      n_bad++;
      $display("FAIL 8n1_idle_after_stop: got %b, required 1", bus.RxIdle);
    end
    ticks(8);
    n_cmp++;
    if (wr_cnt - w0 !== 1) begin
      n_bad++;
      $display("FAIL 8n1_write_count: got %0d, required 1", wr_cnt - w0);
    end
    n_cmp++;
    if (bus.RF_WD !== 11'h055) begin
      n_bad++;
      $display("FAIL 8n1_wd_held: got %h, required 055", bus.RF_WD);
    end
    check_drained("8n1");
  endtask

  task automatic test_parity();
    // 7-bit even parity: 0x41 has two ones
    bus.Len = 1'b1; bus.ParEn = 1'b0; bus.Par = 2'd1;
    exp_q.push_back(11'h041);
    send(8'h41, 7, 1, 1'b0, 1'b1, -1, 1000);
    ticks(8);
    exp_q.push_back(11'h141);
    send(8'h41, 7, 1, 1'b1, 1'b1, -1, 1000);
    ticks(8);
    // 8-bit odd parity: 0x3C has four ones, correct P is 1
    bus.Len = 1'b0; bus.ParEn = 1'b1; bus.Par = 2'd0;
    exp_q.push_back(11'h03C);
    send(8'h3C, 8, 1, 1'b1, 1'b1, -1, 1000);
    ticks(8);
    // Space parity with P=1 and mark parity with P=0 are errors
    bus.Par = 2'd2;
    exp_q.push_back(11'h180);
    send(8'h80, 8, 1, 1'b1, 1'b1, -1, 1000);
    ticks(8);
    bus.Par = 2'd3;
    exp_q.push_back(11'h17E);
    send(8'h7E, 8, 1, 1'b0, 1'b1, -1, 1000);
    ticks(8);
    bus.ParEn = 1'b0;
    check_drained("parity");
  endtask

  task automatic test_framing_break();
    int w0;
    w0 = wr_cnt;
    exp_q.push_back(11'h2A5);
    send(8'hA5, 8, 0, 1'b0, 1'b0, -1, 1000);
    bus.RxD = 1'b1;
    ticks(30);
    n_cmp++;
    if (wr_cnt - w0 !== 1 || bus.RxIdle !== 1'b1) begin
      n_bad++;
      $display("FAIL fe_count_idle: got %0d/%b, required 1/1", wr_cnt - w0, bus.RxIdle);
    end
    check_drained("fe");
    // Line low for three character times
    w0 = wr_cnt;
    exp_q.push_back(11'h600);
    send(8'h00, 8, 0, 1'b0, 1'b0, -1, 1000);
    n_cmp++;
    if (bus.RxStop !== 1'b1) begin
      n_bad++;
      $display("FAIL brk_stop_early: got %b, required 1", bus.RxStop);
    end
    ticks(320);
    n_cmp++;
    if (bus.RxStop !== 1'b1 || wr_cnt - w0 !== 1) begin
      n_bad++;
      $display("FAIL brk_held: RxStop=%b writes=%0d, required 1/1", bus.RxStop, wr_cnt - w0);
    end
    bus.RxD = 1'b1;
    ticks(4);
    n_cmp++;
    if (bus.RxIdle !== 1'b1) begin
      n_bad++;
      $display("FAIL brk_release_idle: got %b, required 1", bus.RxIdle);
    end
    ticks(20);
    check_drained("brk");
  endtask

  task automatic test_glitch();
    int w0;
    w0 = wr_cnt;
    bus.RxD = 1'b0;
    ticks(4);
    n_cmp++;
    if (bus.RxStart !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_start_seen: got %b, required 1", bus.RxStart);
    end
    bus.RxD = 1'b1;
    ticks(40);
    n_cmp++;
    if (wr_cnt - w0 !== 0 || bus.RxIdle !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_rejected: writes=%0d idle=%b, required 0/1", wr_cnt - w0, bus.RxIdle);
    end
`ifdef UART_RXSM_MAJORITY_VOTE_EN
    // One high tick at mid-sample of data bit 3 is outvoted
    exp_q.push_back(11'h000);
    send(8'h00, 8, 0, 1'b0, 1'b1, 4 * 16 + 8, 1000);
    ticks(16);
`endif
    check_drained("glitch");
  endtask

  task automatic test_overrun();
    int w0;
    w0 = wr_cnt;
    bus.RF_FF = 1'b1;
    send(8'h3C, 8, 0, 1'b0, 1'b1, -1, 1000);
    ticks(8);
    n_cmp++;
    if (wr_cnt - w0 !== 0 || bus.OE !== 1'b1) begin
      n_bad++;
      $display("FAIL oe_set: writes=%0d OE=%b, required 0/1", wr_cnt - w0, bus.OE);
    end
    // Next frame with gapped clock enable
    bus.RF_FF = 1'b0;
    ce_div = 3;
    exp_q.push_back(11'h03C);
    send(8'h3C, 8, 0, 1'b0, 1'b1, -1, 1000);
    ticks(8);
    ce_div = 1;
    ticks(4);
    n_cmp++;
    if (wr_cnt - w0 !== 1 || bus.OE !== 1'b0) begin
      n_bad++;
      $display("FAIL oe_clear: writes=%0d OE=%b, required 1/0", wr_cnt - w0, bus.OE);
    end
    check_drained("oe");
  endtask

  task automatic test_reset_midframe();
    int w0;
    send(8'h81, 8, 0, 1'b0, 1'b1, -1, 5 * 16 + 4);
    n_cmp++;
    if (bus.RxShift !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_shift: got %b, required 1", bus.RxShift);
    end
    #2;
    Rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.RxIdle, bus.RxShift, bus.RF_WE, bus.OE} !== 4'b1000 || bus.RF_WD !== 11'h000) begin
      n_bad++;
      $display("FAIL async_reset: flags=%b wd=%h, required 1000/000",
               {bus.RxIdle, bus.RxShift, bus.RF_WE, bus.OE}, bus.RF_WD);
    end
    bus.RxD = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    ticks(20);
    w0 = wr_cnt;
    exp_q.push_back(11'h081);
    send(8'h81, 8, 0, 1'b0, 1'b1, -1, 1000);
    ticks(8);
    n_cmp++;
    if (wr_cnt - w0 !== 1) begin
      n_bad++;
      $display("FAIL post_reset_count: got %0d, required 1", wr_cnt - w0);
    end
    check_drained("post_reset");
  endtask

  initial begin
    bus.CE_16x = 1'b0;
    bus.Len    = 1'b0;
    bus.ParEn  = 1'b0;
    bus.Par    = 2'd0;
    bus.RxD    = 1'b1;
    bus.RF_FF  = 1'b0;
    #1;
    test_reset();
    #22;
    Rst = 1'b1;
    ticks(20);
    test_8n1();
    test_parity();
    test_framing_break();
    test_glitch();
    test_overrun();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
